// File: rtl/dram_ctrl.sv
// DRAM controller for a Z80 system clocked at 4x the CPU clock.
// Translates Z80 memory/refresh cycles into multiplexed-address DRAM
// RAS/CAS timing with RAS-only refresh and a guaranteed precharge.
// All DRAM-facing outputs are registered from the state held during the
// previous cycle, so a request sampled at edge N shows nras low after N+1.
module dram_ctrl #(
    parameter int unsigned TRCD = 1,  // ROW cycles before column mux (1..7)
    parameter int unsigned TRP  = 2   // precharge cycles after RAS low (1..7)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nmreq,
    input  logic        nrd,
    input  logic        nwr,
    input  logic        nrfsh,
    input  logic        nsltsl,
    input  logic [15:0] addr,
    output logic [7:0]  ma,
    output logic        nras,
    output logic        ncas,
    output logic        nwe,
    output logic        ndoe,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ROW  = 3'd1,
        S_COL  = 3'd2,
        S_CAS  = 3'd3,
        S_REF  = 3'd4,
        S_PRE  = 3'd5
    } state_t;

    localparam logic [2:0] TRCD_LD = 3'(TRCD - 1);
    localparam logic [2:0] TRP_LD  = 3'(TRP - 1);

    state_t     state;
    state_t     next_state;
    state_t     prev_state;
    logic [2:0] cnt;
    logic       wr_lat;
    logic       rd_lat;
    logic       entered;

    assign dbg_state = state;
    // A state is "entered" in the first cycle after a change of state.
    assign entered   = (state != prev_state);

    // Next-state decode: refresh wins over access; only nmreq ends a cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!nmreq && !nrfsh)       next_state = S_REF;
                else if (!nmreq && !nsltsl) next_state = S_ROW;
            end
            S_ROW: begin
                if (nmreq)           next_state = S_PRE;
                else if (cnt == 3'd0) next_state = S_COL;
            end
            S_COL: begin
                if (nmreq)             next_state = S_PRE;
                else if (!nrd || !nwr) next_state = S_CAS;
            end
            S_CAS: begin
                if (nmreq) next_state = S_PRE;
            end
            S_REF: begin
                if (nmreq) next_state = S_PRE;
            end
            S_PRE: begin
                if (cnt == 3'd0) next_state = S_IDLE;
            end
            default: next_state = S_PRE;
        endcase
    end

    // State register and shared ROW/PRE down-counter, reloaded on entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_PRE;
            prev_state <= S_PRE;
            cnt        <= TRP_LD;
        end else begin
            state      <= next_state;
            prev_state <= state;
            if (next_state != state) begin
                case (next_state)
                    S_ROW:   cnt <= TRCD_LD;
                    S_PRE:   cnt <= TRP_LD;
                    default: cnt <= cnt;
                endcase
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    // Capture access direction on the COL->CAS edge; write wins over read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_lat <= 1'b0;
            rd_lat <= 1'b0;
        end else if (state == S_COL && next_state == S_CAS) begin
            wr_lat <= !nwr;
            rd_lat <= nwr && !nrd;
        end
    end

    // Registered DRAM strobes and multiplexed address.
    always_ff @(posedge clk) begin
        if (rst) begin
            nras <= 1'b1;
            ncas <= 1'b1;
            nwe  <= 1'b1;
            ndoe <= 1'b1;
            ma   <= 8'h00;
        end else begin
            nras <= !(state inside {S_ROW, S_COL, S_CAS, S_REF});
            ncas <= (state != S_CAS);
            nwe  <= !(state == S_CAS && wr_lat);
            ndoe <= !(state == S_CAS && rd_lat);
            if (entered) begin
                case (state)
                    S_ROW, S_REF: ma <= addr[7:0];
                    S_COL:        ma <= addr[15:8];
                    default:      ma <= ma;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Testbench for dram_ctrl (TRCD=1, TRP=2). Directed cycle-by-cycle vectors;
// each vector carries the hand-derived output word expected after the edge:
// exp = {nras, ncas, nwe, ndoe, ma[7:0]} written as 12'hSMM.
module tb_dram_ctrl;

    logic        clk;
    logic        rst;
    logic        nmreq;
    logic        nrd;
    logic        nwr;
    logic        nrfsh;
    logic        nsltsl;
    logic [15:0] addr;
    logic [7:0]  ma;
    logic        nras;
    logic        ncas;
    logic        nwe;
    logic        ndoe;
    logic [2:0]  dbg_state;

    logic [11:0] exp_q[$];
    int          n_cmp;
    int          n_err;
    int          vec_id;

    dram_ctrl #(.TRCD(1), .TRP(2)) dut (
        .clk(clk), .rst(rst), .nmreq(nmreq), .nrd(nrd), .nwr(nwr),
        .nrfsh(nrfsh), .nsltsl(nsltsl), .addr(addr), .ma(ma),
        .nras(nras), .ncas(ncas), .nwe(nwe), .ndoe(ndoe),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: apply one cycle of inputs at negedge and queue the expectation.
    task automatic step(input logic r, input logic mreq, input logic rd,
                        input logic wr, input logic rfsh, input logic sl,
                        input logic [15:0] a, input logic [11:0] e);
        @(negedge clk);
        rst    = r;
        nmreq  = mreq;
        nrd    = rd;
        nwr    = wr;
        nrfsh  = rfsh;
        nsltsl = sl;
        addr   = a;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input logic [11:0] e);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, e);
    endtask

    // Monitor: compare outputs after every edge that has an expectation.
    always @(posedge clk) begin
        logic [11:0] e;
        logic [11:0] act;
        #1;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            act = {nras, ncas, nwe, ndoe, ma};
            vec_id++;
            n_cmp++;
            if (act !== e) begin
                n_err++;
                $display("FAIL out vec %0d: got %03h need %03h", vec_id, act, e);
            end
            n_cmp++;
            if ((!ncas && nras) || ((!nwe || !ndoe) && ncas)) begin
                n_err++;
                $display("FAIL strobe_rule vec %0d: got %03h need cas-qualified strobes",
                         vec_id, act);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        vec_id = 0;
        rst = 1'b1; nmreq = 1'b1; nrd = 1'b1; nwr = 1'b1;
        nrfsh = 1'b1; nsltsl = 1'b1; addr = 16'h0000;

        // Reset, then precharge runs out to IDLE
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 12'hF00);
        idle(12'hF00); idle(12'hF00); idle(12'hF00);

        // Write 0x1234
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'hF00);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h734);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h712);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h112);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h112);
        step(0, 1, 1, 1, 1, 0, 16'h1234, 12'h112);
        idle(12'hF12); idle(12'hF12); idle(12'hF12);

        // Refresh 0x007F, slot not selected
        step(0, 0, 1, 1, 0, 1, 16'h007F, 12'hF12);
        step(0, 0, 1, 1, 0, 1, 16'h007F, 12'h77F);
        step(0, 0, 1, 1, 0, 1, 16'h007F, 12'h77F);
        step(0, 1, 1, 1, 1, 1, 16'h007F, 12'h77F);
        idle(12'hF7F); idle(12'hF7F); idle(12'hF7F);

        // Refresh priority over a simultaneous slot read
        step(0, 0, 0, 1, 0, 0, 16'h12AB, 12'hF7F);
        step(0, 0, 0, 1, 0, 0, 16'h12AB, 12'h7AB);
        step(0, 0, 0, 1, 0, 0, 16'h12AB, 12'h7AB);
        step(0, 1, 1, 1, 1, 1, 16'h12AB, 12'h7AB);
        idle(12'hFAB); idle(12'hFAB); idle(12'hFAB);

        // Read 0x1234
        step(0, 0, 0, 1, 1, 0, 16'h1234, 12'hFAB);
        step(0, 0, 0, 1, 1, 0, 16'h1234, 12'h734);
        step(0, 0, 0, 1, 1, 0, 16'h1234, 12'h712);
        step(0, 0, 0, 1, 1, 0, 16'h1234, 12'h212);
        step(0, 1, 1, 1, 1, 0, 16'h1234, 12'h212);
        idle(12'hF12); idle(12'hF12); idle(12'hF12);

        // nrd and nwr both low at COL exit: treated as write
        step(0, 0, 0, 0, 1, 0, 16'hA55A, 12'hF12);
        step(0, 0, 0, 0, 1, 0, 16'hA55A, 12'h75A);
        step(0, 0, 0, 0, 1, 0, 16'hA55A, 12'h7A5);
        step(0, 0, 0, 0, 1, 0, 16'hA55A, 12'h1A5);
        step(0, 1, 1, 1, 1, 0, 16'hA55A, 12'h1A5);
        idle(12'hFA5); idle(12'hFA5); idle(12'hFA5);

        // COL waits for a late strobe; nsltsl rising mid-access is ignored
        step(0, 0, 1, 1, 1, 0, 16'h3C81, 12'hFA5);
        step(0, 0, 1, 1, 1, 1, 16'h3C81, 12'h781);
        step(0, 0, 1, 1, 1, 1, 16'h3C81, 12'h73C);
        step(0, 0, 1, 1, 1, 1, 16'h3C81, 12'h73C);
        step(0, 0, 1, 0, 1, 1, 16'h3C81, 12'h73C);
        step(0, 0, 1, 0, 1, 1, 16'h3C81, 12'h13C);
        step(0, 1, 1, 1, 1, 1, 16'h3C81, 12'h13C);
        idle(12'hF3C); idle(12'hF3C);

        // Abort in ROW: nmreq low for one cycle only
        step(0, 0, 1, 1, 1, 0, 16'h0F0F, 12'hF3C);
        step(0, 1, 1, 1, 1, 0, 16'h0F0F, 12'h70F);
        idle(12'hF0F); idle(12'hF0F); idle(12'hF0F);

        // Abort in COL wins over a strobe arriving in the same cycle
        step(0, 0, 1, 1, 1, 0, 16'h4321, 12'hF0F);
        step(0, 0, 1, 1, 1, 0, 16'h4321, 12'h721);
        step(0, 1, 0, 1, 1, 0, 16'h4321, 12'h743);
        idle(12'hF43); idle(12'hF43); idle(12'hF43);

        // Back-to-back: new request during PRE waits for IDLE
        step(0, 0, 1, 1, 1, 0, 16'h2468, 12'hF43);
        step(0, 0, 1, 1, 1, 0, 16'h2468, 12'h768);
        step(0, 0, 1, 0, 1, 0, 16'h2468, 12'h724);
        step(0, 0, 1, 0, 1, 0, 16'h2468, 12'h124);
        step(0, 1, 1, 1, 1, 0, 16'h2468, 12'h124);
        step(0, 0, 0, 1, 1, 0, 16'h1357, 12'hF24);
        step(0, 0, 0, 1, 1, 0, 16'h1357, 12'hF24);
        step(0, 0, 0, 1, 1, 0, 16'h1357, 12'hF24);
        step(0, 0, 0, 1, 1, 0, 16'h1357, 12'h757);
        step(0, 0, 0, 1, 1, 0, 16'h1357, 12'h713);
        step(0, 0, 0, 1, 1, 0, 16'h1357, 12'h213);
        step(0, 1, 1, 1, 1, 0, 16'h1357, 12'h213);
        idle(12'hF13); idle(12'hF13); idle(12'hF13);

        // Reset for one cycle during a write CAS, request kept asserted
        step(0, 0, 1, 1, 1, 0, 16'h1234, 12'hF13);
        step(0, 0, 1, 1, 1, 0, 16'h1234, 12'h734);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h712);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h112);
        step(1, 0, 1, 0, 1, 0, 16'h1234, 12'hF00);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'hF00);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'hF00);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'hF00);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h734);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h712);
        step(0, 0, 1, 0, 1, 0, 16'h1234, 12'h112);
        step(0, 1, 1, 1, 1, 0, 16'h1234, 12'h112);
        idle(12'hF12); idle(12'hF12); idle(12'hF12);

        // Reset held several cycles with a pending request, then an abort
        step(1, 0, 1, 1, 1, 0, 16'hBEEF, 12'hF00);
        step(1, 0, 1, 1, 1, 0, 16'hBEEF, 12'hF00);
        step(1, 0, 1, 1, 1, 0, 16'hBEEF, 12'hF00);
        step(0, 0, 1, 1, 1, 0, 16'hBEEF, 12'hF00);
        step(0, 0, 1, 1, 1, 0, 16'hBEEF, 12'hF00);
        step(0, 0, 1, 1, 1, 0, 16'hBEEF, 12'hF00);
        step(0, 1, 1, 1, 1, 0, 16'hBEEF, 12'h7EF);
        idle(12'hFEF); idle(12'hFEF); idle(12'hFEF);

        // Drain the scoreboard
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
